// File: rtl/repetition_decoder_if.sv
// Chip-stream input and decoded-word valid/ready output of the repetition decoder.
// Signal suffixes are from the decoder's point of view.
interface repetition_decoder_if #(
   parameter int DATA_W = 8
);
   logic              sync_i;
   logic              x_i;
   logic              x_valid_i;
   logic [DATA_W-1:0] y_o;
   logic              y_valid_o;
   logic              y_ready_i;

   modport master (
      output sync_i, x_i, x_valid_i, y_ready_i,
      input  y_o, y_valid_o
   );

   modport slave (
      input  sync_i, x_i, x_valid_i, y_ready_i,
      output y_o, y_valid_o
   );
endinterface

// File: rtl/repetition_decoder.sv
// Majority-vote decoder for REP-times repeated chips, assembling LSB-first DATA_W-bit words
// with correction reporting and sticky overflow on dropped words.
module repetition_decoder #(
   parameter int REP    = 3,
   parameter int DATA_W = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   repetition_decoder_if.slave  bus,
   output logic                 corr_o,
   output logic [15:0]          err_cnt_o,
   output logic                 overflow_o
);

   localparam int CW = $clog2(REP);
   localparam int OW = $clog2(REP + 1);
   localparam int BW = $clog2(DATA_W);

   localparam logic [CW-1:0] CHIP_LAST = CW'(REP - 1);
   localparam logic [OW-1:0] HALF      = OW'((REP - 1) / 2);
   localparam logic [OW-1:0] ALL_ONES  = OW'(REP);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);

   logic [CW-1:0]     chip_q, chip_d;
   logic [OW-1:0]     ones_q, ones_d;
   logic [BW-1:0]     bit_q, bit_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [DATA_W-1:0] y_q, y_d;
   logic              y_valid_q, y_valid_d;
   logic              corr_q, corr_d;
   logic [15:0]       err_q, err_d;
   logic              ovf_q, ovf_d;

   logic [OW-1:0]     total;
   logic              grp_done;
   logic              bit_val;
   logic              grp_corr;
   logic              word_done;
   logic [DATA_W-1:0] word;

   always_comb begin
      total     = ones_q + OW'(bus.x_i);
      grp_done  = bus.x_valid_i && !bus.sync_i && (chip_q == CHIP_LAST);
      bit_val   = total > HALF;
      grp_corr  = grp_done && (total != '0) && (total != ALL_ONES);
      word      = {bit_val, shift_q[DATA_W-1:1]};
      word_done = grp_done && (bit_q == BIT_LAST);

      chip_d    = chip_q;
      ones_d    = ones_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      y_d       = y_q;
      y_valid_d = y_valid_q;
      ovf_d     = ovf_q;
      corr_d    = grp_corr;
      err_d     = (grp_corr && (err_q != 16'hFFFF)) ? err_q + 16'd1 : err_q;

      // sync wins over a chip arriving in the same cycle; that chip is dropped
      if (bus.sync_i) begin
         chip_d  = '0;
         ones_d  = '0;
         bit_d   = '0;
         shift_d = '0;
      end else if (bus.x_valid_i) begin
         if (grp_done) begin
            chip_d  = '0;
            ones_d  = '0;
            shift_d = word;
            bit_d   = (bit_q == BIT_LAST) ? '0 : bit_q + BW'(1);
         end else begin
            chip_d = chip_q + CW'(1);
            ones_d = total;
         end
      end

      // a word completing against a stalled consumer is dropped, not queued
      if (word_done) begin
         if (!y_valid_q || bus.y_ready_i) begin
            y_d       = word;
            y_valid_d = 1'b1;
         end else begin
            ovf_d = 1'b1;
         end
      end else if (y_valid_q && bus.y_ready_i) begin
         y_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         chip_q    <= '0;
         ones_q    <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         y_q       <= '0;
         y_valid_q <= 1'b0;
         corr_q    <= 1'b0;
         err_q     <= '0;
         ovf_q     <= 1'b0;
      end else begin
         chip_q    <= chip_d;
         ones_q    <= ones_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         y_q       <= y_d;
         y_valid_q <= y_valid_d;
         corr_q    <= corr_d;
         err_q     <= err_d;
         ovf_q     <= ovf_d;
      end
   end

   assign bus.y_o       = y_q;
   assign bus.y_valid_o = y_valid_q;
   assign corr_o        = corr_q;
   assign err_cnt_o     = err_q;
   assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_repetition_decoder.sv
// Directed and randomized checks of repetition_decoder against a word-level majority-vote model.
module tb_repetition_decoder;
   localparam int REP = 3;
   localparam int DW  = 8;
   localparam int NCH = REP * DW;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b1;
   logic        corr_o;
   logic [15:0] err_cnt_o;
   logic        overflow_o;

   repetition_decoder_if #(.DATA_W(DW)) bus ();

   repetition_decoder #(.REP(REP), .DATA_W(DW)) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .bus        (bus),
      .corr_o     (corr_o),
      .err_cnt_o  (err_cnt_o),
      .overflow_o (overflow_o)
   );

   always #5 clk_i = ~clk_i;

   int       n_tests = 0;
   int       n_fail  = 0;
   logic [7:0] m_y;
   bit       m_valid, m_ovf, m_corr;
   int       m_err;
   bit       gaps_en, rand_ready;
   int       saved_err;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: update the model for what the DUT samples on this edge, then compare.
   task automatic tick(input bit fin_grp, input bit grp_corr, input bit fin_word, input logic [7:0] w);
      if (rand_ready) bus.y_ready_i = 1'($urandom_range(0, 1));
      if (fin_word) begin
         if (!m_valid || bus.y_ready_i) begin
            m_y     = w;
            m_valid = 1'b1;
         end else begin
            m_ovf = 1'b1;
         end
      end else if (m_valid && bus.y_ready_i) begin
         m_valid = 1'b0;
      end
      m_corr = fin_grp && grp_corr;
      if (m_corr && m_err < 65535) m_err++;
      @(posedge clk_i);
      #1;
      chk("corr", 32'(corr_o), 32'(m_corr));
      chk("err_cnt", 32'(err_cnt_o), 32'(m_err));
      chk("y_valid", 32'(bus.y_valid_o), 32'(m_valid));
      chk("overflow", 32'(overflow_o), 32'(m_ovf));
      if (m_valid) chk("y", 32'(bus.y_o), 32'(m_y));
   endtask

   task automatic send(input logic [7:0] data, input logic [NCH-1:0] flips, input int nchip,
                       input bit ready_last);
      logic [NCH-1:0] chips;
      logic [7:0]     w;
      int             cnt [DW];
      for (int i = 0; i < NCH; i++) chips[i] = data[i / REP] ^ flips[i];
      for (int g = 0; g < DW; g++) begin
         cnt[g] = 0;
         for (int k = 0; k < REP; k++) cnt[g] += int'(chips[g * REP + k]);
         w[g] = (2 * cnt[g] > REP);
      end
      if (ready_last) bus.y_ready_i = 1'b0;
      for (int i = 0; i < nchip; i++) begin
         if (gaps_en) begin
            repeat ($urandom_range(0, 2)) begin
               bus.x_valid_i = 1'b0;
               bus.x_i       = 1'($urandom_range(0, 1));
               tick(1'b0, 1'b0, 1'b0, 8'h00);
            end
         end
         bus.x_valid_i = 1'b1;
         bus.x_i       = chips[i];
         if (ready_last) bus.y_ready_i = (i == NCH - 1);
         tick((i % REP) == REP - 1, cnt[i / REP] != 0 && cnt[i / REP] != REP, i == NCH - 1, w);
      end
      bus.x_valid_i = 1'b0;
      if (ready_last) bus.y_ready_i = 1'b0;
   endtask

   task automatic do_reset();
      bus.x_valid_i = 1'b0;
      bus.sync_i    = 1'b0;
      rst_ni        = 1'b0;
      #2;
      chk("rst_y", 32'(bus.y_o), 32'h0);
      chk("rst_y_valid", 32'(bus.y_valid_o), 32'h0);
      chk("rst_corr", 32'(corr_o), 32'h0);
      chk("rst_err_cnt", 32'(err_cnt_o), 32'h0);
      chk("rst_overflow", 32'(overflow_o), 32'h0);
      @(posedge clk_i);
      #1;
      rst_ni  = 1'b1;
      m_y     = 8'h00;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_corr  = 1'b0;
      m_err   = 0;
   endtask

   initial begin
      logic [NCH-1:0] fl;
      bus.sync_i    = 1'b0;
      bus.x_i       = 1'b0;
      bus.x_valid_i = 1'b0;
      bus.y_ready_i = 1'b1;
      gaps_en       = 1'b0;
      rand_ready    = 1'b0;
      #3;
      do_reset();

      // clean word
      send(8'hA5, '0, NCH, 1'b0);
      repeat (3) tick(1'b0, 1'b0, 1'b0, 8'h00);
      chk("clean_y", 32'(bus.y_o), 32'hA5);
      chk("clean_err", 32'(err_cnt_o), 32'd0);

      // middle chip of every group flipped, with gaps
      gaps_en = 1'b1;
      fl = '0;
      for (int g = 0; g < DW; g++) fl[g * REP + 1] = 1'b1;
      send(8'h3C, fl, NCH, 1'b0);
      chk("single_y", 32'(bus.y_o), 32'h3C);
      chk("single_err", 32'(err_cnt_o), 32'd8);

      // two of three chips flipped: miscorrection
      gaps_en = 1'b0;
      send(8'h01, NCH'(3), NCH, 1'b0);
      chk("double_y", 32'(bus.y_o), 32'h00);
      chk("double_err", 32'(err_cnt_o), 32'd9);

      // backpressure drops the second word
      do_reset();
      bus.y_ready_i = 1'b0;
      send(8'h11, '0, NCH, 1'b0);
      send(8'h22, '0, NCH, 1'b0);
      chk("bp_y", 32'(bus.y_o), 32'h11);
      chk("bp_overflow", 32'(overflow_o), 32'd1);
      bus.y_ready_i = 1'b1;
      tick(1'b0, 1'b0, 1'b0, 8'h00);
      bus.y_ready_i = 1'b0;
      tick(1'b0, 1'b0, 1'b0, 8'h00);
      chk("bp_drain_valid", 32'(bus.y_valid_o), 32'd0);
      chk("bp_drain_overflow", 32'(overflow_o), 32'd1);

      // accept and replace in the same cycle
      do_reset();
      bus.y_ready_i = 1'b0;
      send(8'h11, '0, NCH, 1'b0);
      send(8'h22, '0, NCH, 1'b1);
      chk("simul_y", 32'(bus.y_o), 32'h22);
      chk("simul_valid", 32'(bus.y_valid_o), 32'd1);
      chk("simul_overflow", 32'(overflow_o), 32'd0);
      bus.y_ready_i = 1'b1;
      tick(1'b0, 1'b0, 1'b0, 8'h00);

      // reset mid-word
      send(8'h77, NCH'(2), 10, 1'b0);
      do_reset();
      send(8'h5A, '0, NCH, 1'b0);
      chk("rst_resync_y", 32'(bus.y_o), 32'h5A);

      // sync mid-word, chip in the same cycle is discarded
      gaps_en = 1'b1;
      send(8'hC3, NCH'(2), 10, 1'b0);
      saved_err     = m_err;
      bus.sync_i    = 1'b1;
      bus.x_valid_i = 1'b1;
      bus.x_i       = 1'b1;
      tick(1'b0, 1'b0, 1'b0, 8'h00);
      bus.sync_i    = 1'b0;
      bus.x_valid_i = 1'b0;
      send(8'h5A, '0, NCH, 1'b0);
      chk("sync_resync_y", 32'(bus.y_o), 32'h5A);
      chk("sync_err_kept", 32'(err_cnt_o), 32'(saved_err));
      chk("sync_err_nonzero", 32'(err_cnt_o), 32'd1);

      // random words, random chip flips, random gaps and backpressure
      rand_ready = 1'b1;
      repeat (20) send(8'($urandom), NCH'($urandom & $urandom), NCH, 1'b0);
      repeat (4) tick(1'b0, 1'b0, 1'b0, 8'h00);
      rand_ready = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/repetition_decoder.md
# repetition_decoder

Receive-side decoder for the repetition-coded serial link used to carry data across unreliable gate fabric. It accepts a stream of coded chips where every data bit is repeated REP times and recovers each bit by majority vote. Decoded bits are assembled LSB-first into DATA_W-bit words and presented on a valid/ready output. The block also reports every corrected bit, keeps a saturating correction count, and flags dropped words.

## Interface
- REP, 3, chips per data bit; odd, ≥3
- DATA_W, 8, bits per decoded word; ≥2
- clk_i  input  1  clock; all logic on the rising edge
- rst_ni  input  1  reset, asynchronous and active-low
- sync_i  input  1  word-alignment strobe; clears the chip and bit position
- x_i  input  1  coded chip
- x_valid_i  input  1  x_i carries a chip this cycle
- y_o  output  DATA_W  decoded word; bit 0 is the first decoded bit
- y_valid_o  output  1  y_o holds an unconsumed word
- y_ready_i  input  1  consumer accepts y_o this cycle
- corr_o  output  1  one-cycle pulse: the last completed chip group was not unanimous
- err_cnt_o  output  16  count of non-unanimous groups; saturates at 0xFFFF
- overflow_o  output  1  sticky: a completed word was dropped

## Operation
- Chip counter chip_q counts 0..REP-1. Ones counter ones_q is clog2(REP+1) bits wide. Both advance only when x_valid_i=1.
- A group completes on a valid chip with chip_q=REP-1.
  - The decoded bit is 1 when (ones_q + x_i) > (REP-1)/2.
  - The group is unanimous when the total is 0 or REP; otherwise it is a correction.
  - On completion, chip_q and ones_q clear and the decoded bit shifts into the word: shift_q = {bit, shift_q[DATA_W-1:1]}.
- Bit counter bit_q counts 0..DATA_W-1 and advances once per completed group. The group with bit_q=DATA_W-1 completes the word, and bit_q wraps to 0.
- Output register behaviour:
  - A completed word loads y_o and sets y_valid_o if y_valid_o=0, or if y_valid_o=1 and y_ready_i=1 in the same cycle (accept and replace; no overflow).
  - If y_valid_o=1 and y_ready_i=0, the completed word is discarded, y_o is unchanged, and overflow_o is set.
  - A handshake (y_valid_o and y_ready_i) with no new word clears y_valid_o.
- A correction pulses corr_o and increments err_cnt_o, saturating at 0xFFFF.
- sync_i clears chip_q, ones_q, bit_q and shift_q. It has priority over a chip arriving in the same cycle; that chip is discarded. sync_i does not affect y_o, y_valid_o, err_cnt_o or overflow_o.
- overflow_o and err_cnt_o clear only on reset.
- Reset, asynchronous and active-low, mid-word: the partial group and partial word are lost. Decoding restarts at chip 0, bit 0.

## Timing
- Reset values: y_o=0, y_valid_o=0, corr_o=0, err_cnt_o=0, overflow_o=0. All internal counters and shift_q are 0.
- Decode latency: y_valid_o rises on the clock edge after the last chip of a word is sampled.
- corr_o and the err_cnt_o increment appear on the edge after the chip that completes the group.
- The block accepts one chip per cycle with no stall; there is no backpressure on x_i.
- y_o is stable while y_valid_o=1 and y_ready_i=0.
- Gaps (x_valid_i=0) may fall anywhere, including inside a group, with no effect on decoding.

## Test plan
All scenarios use REP=3 and DATA_W=8.
- Clean word: 0xA5 sent LSB-first, each bit as three identical chips (24 chips), y_ready_i=1 → y_o=0xA5 with y_valid_o for 1 cycle, starting the edge after chip 24; corr_o never pulses; err_cnt_o=0.
- Single flips: 0x3C with the middle chip of every group inverted, random x_valid_i gaps → y_o=0x3C; 8 corr_o pulses; err_cnt_o=8.
- Double flip: 0x01 with chips 0 and 1 of group 0 inverted → y_o=0x00 (miscorrection); err_cnt_o=1.
- Backpressure: y_ready_i=0; send 0x11 then 0x22 → y_o stays 0x11 and overflow_o=1. Then pulse y_ready_i for 1 cycle → y_valid_o=0 and overflow_o remains 1.
- Simultaneous accept: y_valid_o=1 with 0x11 held; assert y_ready_i in the exact cycle 0x22 completes → y_o=0x22, y_valid_o=1, overflow_o=0.
- Reset and resync:
  - Assert rst_ni low after 10 chips, then send 0x5A in full → y_o=0x5A.
  - Repeat using sync_i in place of reset → y_o=0x5A, and err_cnt_o is preserved.
